// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scanner with guard window, hex/raw modes and blanking.
// Define SEG7_PWM_EN to build the 16-level brightness gating; otherwise digits run at full brightness.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int PHASE_CYCLES = 98,
    parameter int GUARD_CYCLES = 2,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_raw,
    input  logic [NUM_DIGITS-1:0] i_blank,
    input  logic [3:0]            i_bright,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic                  o_frame
);
    localparam int SLOT = 16 * PHASE_CYCLES;
    localparam int CW   = $clog2(SLOT);
    localparam int IW   = $clog2(NUM_DIGITS);

    logic [7:0]            mem [NUM_DIGITS];
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic                  term, blank_q, blank_n;
    logic [7:0]            d;
    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  lit;
`ifdef SEG7_PWM_EN
    logic [3:0]            bright_q, bright_n, p;
`else
    logic                  unused_bright;
    assign unused_bright = ^i_bright;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Anodes are registered from next-cycle counter values so they line up with the loaded segments.
    always_comb begin
        term    = cnt == CW'(SLOT - 1);
        cnt_n   = term ? '0 : cnt + 1'b1;
        idx_n   = term ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
        d       = mem[idx_n];
        seg_n   = i_raw ? ~d[6:0] : hex7(d[3:0]);
        blank_n = term ? i_blank[idx_n] : blank_q;
`ifdef SEG7_PWM_EN
        bright_n = term ? i_bright : bright_q;
        p        = 4'(32'(cnt_n) / PHASE_CYCLES);
        lit      = !blank_n && cnt_n >= CW'(GUARD_CYCLES) && p <= bright_n;
`else
        lit      = !blank_n && cnt_n >= CW'(GUARD_CYCLES);
`endif
        an_n        = '1;
        an_n[idx_n] = !lit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            o_an    <= '1;
            o_seg   <= 7'h7F;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
            blank_q <= 1'b1;
`ifdef SEG7_PWM_EN
            bright_q <= 4'hF;
`endif
            for (int i = 0; i < NUM_DIGITS; i++) mem[i] <= '0;
        end else begin
            cnt     <= cnt_n;
            idx     <= idx_n;
            blank_q <= blank_n;
            o_an    <= an_n;
            o_frame <= term && idx == IW'(NUM_DIGITS - 1);
`ifdef SEG7_PWM_EN
            bright_q <= bright_n;
`endif
            if (term) begin
                o_seg <= seg_n;
                o_dp  <= ~d[7];
            end
            if (i_wr_en && 32'(i_wr_idx) < NUM_DIGITS) mem[i_wr_idx[IW-1:0]] <= i_wr_data;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scanning, decode, blanking, brightness and reset.
module tb_seg7_scan_ctrl;
    logic       clk = 0;
    logic       rst = 1;
    logic       i_wr_en = 0;
    logic [3:0] i_wr_idx = 0;
    logic [7:0] i_wr_data = 0;
    logic       i_raw = 0;
    logic [3:0] i_blank = 0;
    logic [3:0] i_bright = 4'hF;
    logic [3:0] o_an;
    logic [6:0] o_seg;
    logic       o_dp;
    logic       o_frame;
    int errors = 0;
    int checks = 0;
    int t = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .PHASE_CYCLES(4), .GUARD_CYCLES(2), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .i_raw(i_raw), .i_blank(i_blank), .i_bright(i_bright),
        .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        t = 0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [7:0] data);
        i_wr_en = 1;
        i_wr_idx = idx;
        i_wr_data = data;
        tick();
        i_wr_en = 0;
    endtask

    task automatic next_slot();
        tick();
        while (t % 64 != 0) tick();
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (o_an !== 4'hF || o_seg !== 7'h7F || o_dp !== 1'b1 || o_frame !== 1'b0) begin
            errors++;
            $display("FAIL %s: an=%h seg=%h dp=%b frame=%b, want an=f seg=7f dp=1 frame=0",
                     name, o_an, o_seg, o_dp, o_frame);
        end
    endtask

    task automatic measure(input string name, input logic [6:0] exp_seg, input logic exp_dp,
                           input int exp_low);
        int low = 0;
        int first = -1;
        int sidx = (t / 64) % 4;
        logic bad = 0;
        logic [3:0] want_an = ~(4'b0001 << sidx);
        logic [6:0] seg0 = o_seg;
        logic dp0 = o_dp;
        for (int c = 0; c < 64; c++) begin
            if (o_an !== 4'hF) begin
                low++;
                if (first < 0) first = c;
                if (o_an !== want_an) bad = 1;
            end
            if (o_seg !== seg0 || o_dp !== dp0) bad = 1;
            tick();
        end
        checks += 4;
        if (seg0 !== exp_seg) begin
            errors++;
            $display("FAIL %s seg: got %h want %h", name, seg0, exp_seg);
        end
        if (dp0 !== exp_dp) begin
            errors++;
            $display("FAIL %s dp: got %b want %b", name, dp0, exp_dp);
        end
        if (low != exp_low) begin
            errors++;
            $display("FAIL %s on_time: got %0d want %0d", name, low, exp_low);
        end
        if (bad) begin
            errors++;
            $display("FAIL %s shape: wrong anode or segment change mid-slot, got bad=1 want 0", name);
        end
        if (exp_low > 0) begin
            checks++;
            if (first != 2) begin
                errors++;
                $display("FAIL %s first_on: got %0d want 2", name, first);
            end
        end
    endtask

    task automatic load_hex();
        wr(0, 8'h00);
        wr(1, 8'h81);
        wr(2, 8'h0A);
        wr(3, 8'h0F);
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_vals("reset");
        measure("idle_slot0", 7'h7F, 1'b1, 0);
        while (t < 255) tick();
        checks++;
        if (o_frame !== 1'b0) begin
            errors++;
            $display("FAIL frame_pre: got %b want 0", o_frame);
        end
        tick();
        checks++;
        if (o_frame !== 1'b1) begin
            errors++;
            $display("FAIL frame_256: got %b want 1", o_frame);
        end
        tick();
        checks++;
        if (o_frame !== 1'b0) begin
            errors++;
            $display("FAIL frame_post: got %b want 0", o_frame);
        end
        while (t < 512) tick();
        checks++;
        if (o_frame !== 1'b1) begin
            errors++;
            $display("FAIL frame_512: got %b want 1", o_frame);
        end
    endtask

    task automatic test_hex();
        do_reset();
        i_raw = 0; i_blank = 0; i_bright = 4'hF;
        load_hex();
        next_slot();
        measure("hex_d1", 7'h79, 1'b0, 62);
        measure("hex_d2", 7'h08, 1'b1, 62);
        measure("hex_d3", 7'h0E, 1'b1, 62);
        measure("hex_d0", 7'h40, 1'b1, 62);
    endtask

    task automatic test_raw();
        do_reset();
        i_raw = 1; i_blank = 0; i_bright = 4'hF;
        wr(2, 8'h49);
        next_slot();
        next_slot();
        measure("raw_d2", 7'h36, 1'b1, 62);
        i_raw = 0;
    endtask

    task automatic test_bright();
        do_reset();
        i_raw = 0; i_blank = 0; i_bright = 4'd3;
        load_hex();
        next_slot();
`ifdef SEG7_PWM_EN
        measure("bright3", 7'h79, 1'b0, 14);
`else
        measure("bright3", 7'h79, 1'b0, 62);
`endif
        i_bright = 4'd0;
        next_slot();
`ifdef SEG7_PWM_EN
        measure("bright0", 7'h0E, 1'b1, 2);
`else
        measure("bright0", 7'h0E, 1'b1, 62);
`endif
        i_bright = 4'hF;
    endtask

    task automatic test_blank();
        do_reset();
        i_raw = 0; i_blank = 4'b0100; i_bright = 4'hF;
        load_hex();
        wr(5, 8'hFF);
        next_slot();
        measure("blank_d1", 7'h79, 1'b0, 62);
        measure("blank_d2", 7'h08, 1'b1, 0);
        measure("blank_d3", 7'h0E, 1'b1, 62);
        measure("blank_d0", 7'h40, 1'b1, 62);
        i_blank = 0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        i_raw = 0; i_blank = 0; i_bright = 4'hF;
        load_hex();
        while (t < 94) tick();
        rst = 1;
        tick();
        check_reset_vals("rst_mid");
        rst = 0;
        t = 0;
        measure("rst_slot0", 7'h7F, 1'b1, 0);
        measure("rst_d1", 7'h40, 1'b1, 62);
    endtask

    initial begin
        test_reset();
        test_hex();
        test_raw();
        test_bright();
        test_blank();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
